// File: rtl/mio_bus_responder.sv
// CPU-bus memory/IO responder: word RAM with fixed wait states plus a small
// GPIO/timer/interrupt register bank, answering each request with one ready pulse.
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int RAM_LATENCY = 2,
  parameter int GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mio_req,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic              int_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam int CNT_W = $clog2(RAM_LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [RAM_AW-1:0]  ramIdx_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [31:0]        mem [2**RAM_AW];
  logic [31:0]        rdata_q;
  logic [GPIO_W-1:0]  gpioOut_q;
  logic [31:0]        tmrCnt_q, tmrCnt_d, tmrCmp_q;
  logic [1:0]         tmrCtrl_q;
  logic               intStat_q, intStat_d;

  logic        isRam, isIo, accept, ramDone, ioWrite, tmrMatch;
  logic [2:0]  ioSel;
  logic [31:0] ioRdata;
  logic        unusedAddrBits;

  assign isRam          = (addr[31:RAM_AW+2] == '0);
  assign isIo           = (addr[31:5] == 27'h780_0000);
  assign ioSel          = addr[4:2];
  assign accept         = (state_q == IDLE) && mio_req;
  assign ramDone        = (state_q == BUSY) && (waitCnt_q == '0);
  assign ioWrite        = accept && !isRam && isIo && mem_w;
  assign tmrMatch       = tmrCtrl_q[0] && (tmrCnt_q == tmrCmp_q);
  assign unusedAddrBits = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (mio_req) begin
          if (isRam) begin
            state_d   = BUSY;
            waitCnt_d = CNT_W'(RAM_LATENCY - 1);
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (waitCnt_q == '0) state_d = DONE;
        else                 waitCnt_d = waitCnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mio_ready = (state_q == DONE);
    int_out   = intStat_q & tmrCtrl_q[1];
    rdata     = rdata_q;
    gpio_out  = gpioOut_q;
  end

  // RAM accesses finish from these copies, so the CPU may change its bus mid-wait.
  always_ff @(posedge clk) begin
    if (accept) begin
      ramIdx_q <= addr[RAM_AW+1:2];
      wdata_q  <= wdata;
      we_q     <= mem_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ramDone && we_q) mem[ramIdx_q] <= wdata_q;
  end

  always_comb begin
    ioRdata = '0;
    if (isIo) begin
      case (ioSel)
        3'd0:    ioRdata = 32'(gpioOut_q);
        3'd1:    ioRdata = 32'(gpio_in);
        3'd2:    ioRdata = tmrCnt_q;
        3'd3:    ioRdata = tmrCmp_q;
        3'd4:    ioRdata = {30'b0, tmrCtrl_q};
        3'd5:    ioRdata = {31'b0, intStat_q};
        default: ioRdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  rdata_q <= '0;
    else if (accept && !isRam)  rdata_q <= mem_w ? '0 : ioRdata;
    else if (ramDone)           rdata_q <= we_q ? '0 : mem[ramIdx_q];
  end

  // A bus write to the counter beats increment/wrap; a hardware set beats W1C.
  always_comb begin
    tmrCnt_d = tmrCnt_q;
    if (tmrCtrl_q[0]) tmrCnt_d = tmrMatch ? '0 : tmrCnt_q + 32'd1;
    if (ioWrite && ioSel == 3'd2) tmrCnt_d = wdata;
    intStat_d = intStat_q;
    if (ioWrite && ioSel == 3'd5 && wdata[0]) intStat_d = 1'b0;
    if (tmrMatch) intStat_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpioOut_q <= '0;
      tmrCnt_q  <= '0;
      tmrCmp_q  <= '0;
      tmrCtrl_q <= '0;
      intStat_q <= 1'b0;
    end else begin
      tmrCnt_q  <= tmrCnt_d;
      intStat_q <= intStat_d;
      if (ioWrite && ioSel == 3'd0) gpioOut_q <= wdata[GPIO_W-1:0];
      if (ioWrite && ioSel == 3'd3) tmrCmp_q  <= wdata;
      if (ioWrite && ioSel == 3'd4) tmrCtrl_q <= wdata[1:0];
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed vector table, random
// transactions against a transaction-level memory-map model, and timing sequences.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        reset, mio_req, mem_w;
  logic [31:0] addr, wdata, rdata;
  logic        mio_ready, int_out;
  logic [15:0] gpio_in, gpio_out;

  int tests = 0;
  int fails = 0;
  int cycCnt = 0;

  mio_bus_responder #(.RAM_AW(10), .RAM_LATENCY(2), .GPIO_W(16)) dut (
    .clk(clk), .reset(reset), .mio_req(mio_req), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready), .int_out(int_out),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] gin;
    logic [31:0] expRd;
    int          expLat;
    logic [15:0] expGpio;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [15:0] gin, input logic [31:0] expRd,
                              input int expLat, input logic [15:0] expGpio);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.gin = gin;
    v.expRd = expRd; v.expLat = expLat; v.expGpio = expGpio;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge while the DUT is idle; returns likewise.
  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output int lat, output logic intAtReady);
    mio_req = 1'b1; mem_w = we; addr = a; wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!mio_ready) begin
        mem_w = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
      end
    end while (!mio_ready && lat < 20);
    rd = rdata;
    intAtReady = int_out;
    mio_req = 1'b0; mem_w = 1'b0; addr = $urandom; wdata = $urandom;
    @(posedge clk); #1;
    checkOutput("ready_one_cycle", 32'(mio_ready), 32'd0);
  endtask

  logic [31:0] ramM [int];
  logic [15:0] gpioM;
  logic [31:0] cntM, cmpM;

  initial begin
    logic [31:0] rd, a, d, exp;
    logic [15:0] gin;
    logic        intR, we, early, saw;
    int          lat, expLat, op, idx, sel, cE, p;
    logic [5:0]  readyBits;

    reset = 1'b1; mio_req = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_ready", 32'(mio_ready), 32'd0);
    checkOutput("reset_int", 32'(int_out), 32'd0);
    checkOutput("reset_gpio", 32'(gpio_out), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(mk(1, 32'h0000_0010, 32'h1234_5678, 16'h0, 32'h0, 3, 16'h0));
    vecs.push_back(mk(0, 32'h0000_0010, 32'h0, 16'h0, 32'h1234_5678, 3, 16'h0));
    vecs.push_back(mk(1, 32'hF000_0000, 32'h1234_A5A5, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'hF000_0000, 32'h0, 16'h0, 32'h0000_A5A5, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'hF000_0004, 32'h0, 16'h00FF, 32'h0000_00FF, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'h8000_0000, 32'h0, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(1, 32'h0000_0013, 32'hCAFE_F00D, 16'h0, 32'h0, 3, 16'hA5A5));
    vecs.push_back(mk(0, 32'h0000_0010, 32'h0, 16'h0, 32'hCAFE_F00D, 3, 16'hA5A5));
    vecs.push_back(mk(1, 32'h0000_0FFC, 32'h0BAD_BEEF, 16'h0, 32'h0, 3, 16'hA5A5));
    vecs.push_back(mk(0, 32'h0000_0FFF, 32'h0, 16'h0, 32'h0BAD_BEEF, 3, 16'hA5A5));
    vecs.push_back(mk(0, 32'h0000_1000, 32'h0, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(1, 32'hF000_000C, 32'h0000_0055, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'hF000_000C, 32'h0, 16'h0, 32'h0000_0055, 1, 16'hA5A5));
    vecs.push_back(mk(1, 32'hF000_0010, 32'hFFFF_FFFC, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'hF000_0010, 32'h0, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(1, 32'hF000_0020, 32'h0000_0001, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'hF000_0020, 32'h0, 16'h0, 32'h0, 1, 16'hA5A5));
    vecs.push_back(mk(0, 32'hF000_0014, 32'h0, 16'h0, 32'h0, 1, 16'hA5A5));

    foreach (vecs[i]) begin
      gpio_in = vecs[i].gin;
      applyStimulus(vecs[i].we, vecs[i].a, vecs[i].d, rd, lat, intR);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      if (!vecs[i].we) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].expGpio));
      if (vecs[i].we && vecs[i].a < 32'h1000) ramM[int'(vecs[i].a >> 2)] = vecs[i].d;
    end

    // Timer stays disabled here, so the register bank behaves as plain storage.
    gpioM = 16'hA5A5; cntM = 32'h0; cmpM = 32'h55;
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 5);
      we = 1'b0; d = $urandom; gin = $urandom; exp = 32'h0; expLat = 1;
      idx = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 31);
      if (op == 1 && !ramM.exists(idx)) op = 0;
      case (op)
        0: begin we = 1'b1; a = (idx * 4) | $urandom_range(0, 3); expLat = 3; end
        1: begin a = (idx * 4) | $urandom_range(0, 3); exp = ramM[idx]; expLat = 3; end
        2: begin we = 1'b1; a = 32'hF000_0000; end
        3: begin
          sel = $urandom_range(0, 7);
          a = 32'hF000_0000 + 32'(sel * 4);
          case (sel)
            0: exp = 32'(gpioM);
            1: exp = 32'(gin);
            2: exp = cntM;
            3: exp = cmpM;
            default: exp = 32'h0;
          endcase
        end
        4: begin we = 1'b1; a = ($urandom_range(0, 1) == 1) ? 32'hF000_0008 : 32'hF000_000C; end
        default: begin we = 1'($urandom_range(0, 1)); a = $urandom_range(32'h1000, 32'hEFFF_FFFF); end
      endcase
      gpio_in = gin;
      applyStimulus(we, a, d, rd, lat, intR);
      checkOutput($sformatf("rand%0d_latency", t), 32'(lat), 32'(expLat));
      if (!we) checkOutput($sformatf("rand%0d_rdata", t), rd, exp);
      if (we && op == 0) ramM[idx] = d;
      if (we && op == 2) gpioM = d[15:0];
      if (we && op == 4 && a == 32'hF000_0008) cntM = d;
      if (we && op == 4 && a == 32'hF000_000C) cmpM = d;
      checkOutput($sformatf("rand%0d_gpio", t), 32'(gpio_out), 32'(gpioM));
    end

    // Three back-to-back reads with the request held high.
    gin = $urandom; gpio_in = gin;
    mio_req = 1'b1; mem_w = 1'b0; addr = 32'hF000_0004; readyBits = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      readyBits[k] = mio_ready;
      if (mio_ready) checkOutput($sformatf("b2b_rdata%0d", k), rdata, 32'(gin));
      if (k == 4) mio_req = 1'b0;
    end
    checkOutput("b2b_ready_pattern", 32'(readyBits), 32'b010101);

    // Timer with compare 5: wraps every 6 cycles once enabled.
    applyStimulus(1'b1, 32'hF000_0008, 32'h0, rd, lat, intR);
    applyStimulus(1'b1, 32'hF000_000C, 32'h5, rd, lat, intR);
    cE = cycCnt + 1;
    applyStimulus(1'b1, 32'hF000_0010, 32'h3, rd, lat, intR);
    early = 1'b0;
    while (cycCnt < cE + 6) begin
      early |= int_out;
      @(posedge clk); #1;
    end
    checkOutput("int_before_match", 32'(early), 32'd0);
    checkOutput("int_after_match", 32'(int_out), 32'd1);
    applyStimulus(1'b0, 32'hF000_0008, 32'h0, rd, lat, intR);
    checkOutput("tmr_cnt_after_wrap", rd, 32'd0);
    p = $urandom_range(0, 5);
    while ((cycCnt - cE) % 6 != p) begin @(posedge clk); #1; end
    applyStimulus(1'b0, 32'hF000_0008, 32'h0, rd, lat, intR);
    checkOutput("tmr_cnt_phase", rd, 32'(p));
    while ((cycCnt - cE) % 6 != 0) begin @(posedge clk); #1; end
    applyStimulus(1'b1, 32'hF000_0014, 32'h1, rd, lat, intR);
    checkOutput("w1c_clears_int", 32'(intR), 32'd0);
    checkOutput("int_stays_clear", 32'(int_out), 32'd0);
    while ((cycCnt - cE) % 6 != 5) begin @(posedge clk); #1; end
    applyStimulus(1'b1, 32'hF000_0014, 32'h1, rd, lat, intR);
    checkOutput("set_beats_w1c", 32'(intR), 32'd1);

    // Reset arrives while a RAM write is waiting: the write must be dropped.
    applyStimulus(1'b1, 32'h0000_0020, 32'h600D_F00D, rd, lat, intR);
    mio_req = 1'b1; mem_w = 1'b1; addr = 32'h0000_0020; wdata = 32'hDEAD_DEAD;
    @(posedge clk); #1;
    saw = mio_ready;
    reset = 1'b1;
    @(posedge clk); #1;
    saw |= mio_ready;
    reset = 1'b0; mio_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw |= mio_ready;
    end
    checkOutput("abort_no_ready", 32'(saw), 32'd0);
    checkOutput("abort_gpio_reset", 32'(gpio_out), 32'd0);
    checkOutput("abort_int_reset", 32'(int_out), 32'd0);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, rd, lat, intR);
    checkOutput("abort_read_latency", 32'(lat), 32'd3);
    checkOutput("abort_prior_contents", rd, 32'h600D_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
